// File: rtl/raymarch_scheduler.sv
// raymarch_scheduler: raster-order pixel dispatch to NUM_CORES raymarch
// cores and round-robin write-back of finished pixels to frame-buffer port A.
// Ports: clk_in/rst_in (sync, active high); start_in (level, begins a frame);
//   core_ready_in/core_start_out/pix_x_out/pix_y_out : pixel dispatch;
//   core_done_in/core_x_in/core_y_in/core_rgb_in/core_ack_out : result return;
//   fb_we_out/fb_addr_out/fb_data_out : registered frame-buffer write;
//   frame_done_out (pulse in DONE), timer_out (frame count), busy_out.
module raymarch_scheduler #(
  parameter int WIDTH     = 1280,
  parameter int HEIGHT    = 720,
  parameter int NUM_CORES = 4,
  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
  localparam int AW = (WIDTH*HEIGHT > 1) ? $clog2(WIDTH*HEIGHT) : 1,
  localparam int CW = $clog2(NUM_CORES)
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  input  logic [NUM_CORES-1:0]    core_ready_in,
  output logic [NUM_CORES-1:0]    core_start_out,
  output logic [XW-1:0]           pix_x_out,
  output logic [YW-1:0]           pix_y_out,
  output logic [31:0]             timer_out,
  input  logic [NUM_CORES-1:0]    core_done_in,
  input  logic [NUM_CORES*XW-1:0] core_x_in,
  input  logic [NUM_CORES*YW-1:0] core_y_in,
  input  logic [NUM_CORES*24-1:0] core_rgb_in,
  output logic [NUM_CORES-1:0]    core_ack_out,
  output logic                    fb_we_out,
  output logic [AW-1:0]           fb_addr_out,
  output logic [23:0]             fb_data_out,
  output logic                    frame_done_out,
  output logic                    busy_out
);
  localparam int PW = (CW > 0) ? CW : 1;
  localparam int OW = $clog2(NUM_CORES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DISPATCH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t         r_state;
  logic [XW-1:0]  r_x;
  logic [YW-1:0]  r_y;
  logic [31:0]    r_timer;
  logic [OW-1:0]  r_out;
  logic [PW-1:0]  r_ptr;
  logic           r_we;
  logic [AW-1:0]  r_addr;
  logic [23:0]    r_data;
  logic           r_fdone;
  logic           r_busy;

  logic [NUM_CORES-1:0] w_start_oh;
  logic [NUM_CORES-1:0] w_ack;
  logic                 w_disp;
  logic                 w_arb;
  logic                 w_gnt_any;
  logic                 w_gnt;
  logic [PW-1:0]        w_gnt_idx;
  logic [XW-1:0]        w_gx;
  logic [YW-1:0]        w_gy;
  logic [23:0]          w_grgb;
  logic [AW-1:0]        w_addr;
  logic                 w_last_x;
  logic                 w_last;

  // Strobes are suppressed while reset is held so no core is
  // started or acked by a frame that is being thrown away.
  assign w_start_oh = core_ready_in & (~core_ready_in + NUM_CORES'(1));
  assign w_disp = (r_state == S_DISPATCH) && (|core_ready_in) && !rst_in;
  assign w_arb  = ((r_state == S_DISPATCH) || (r_state == S_DRAIN))
                  && !rst_in;
  assign w_gnt  = w_arb && w_gnt_any;

  assign core_start_out = w_disp ? w_start_oh : '0;
  assign core_ack_out   = w_ack;

  // Round-robin: the second pass (indices above the pointer) overrides
  // the first (wrapped indices), each pass keeping its lowest hit.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_done_in[i] && (PW'(i) <= r_ptr)) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = PW'(i);
      end
    end
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (core_done_in[i] && (PW'(i) > r_ptr)) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = PW'(i);
      end
    end
  end

  always_comb begin
    w_ack  = '0;
    w_gx   = '0;
    w_gy   = '0;
    w_grgb = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_gnt && (w_gnt_idx == PW'(i))) begin
        w_ack[i] = 1'b1;
        w_gx     = core_x_in[i*XW +: XW];
        w_gy     = core_y_in[i*YW +: YW];
        w_grgb   = core_rgb_in[i*24 +: 24];
      end
    end
  end

  assign w_addr   = AW'(w_gx) + AW'(WIDTH) * AW'(w_gy);
  assign w_last_x = (r_x == XW'(WIDTH - 1));
  assign w_last   = w_last_x && (r_y == YW'(HEIGHT - 1));

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_timer <= '0;
      r_out   <= '0;
      r_ptr   <= PW'(NUM_CORES - 1);
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_fdone <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_we    <= w_gnt;
      r_fdone <= 1'b0;
      if (w_gnt) begin
        r_addr <= w_addr;
        r_data <= w_grgb;
        r_ptr  <= w_gnt_idx;
      end
      if (w_disp && !w_gnt)
        r_out <= r_out + OW'(1);
      else if (!w_disp && w_gnt)
        r_out <= r_out - OW'(1);
      if (w_disp) begin
        if (w_last_x) begin
          r_x <= '0;
          r_y <= w_last ? '0 : r_y + YW'(1);
        end else begin
          r_x <= r_x + XW'(1);
        end
      end
      unique case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_state <= S_DISPATCH;
            r_busy  <= 1'b1;
          end
        end
        S_DISPATCH: begin
          if (w_disp && w_last)
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if ((r_out == '0) && !w_gnt) begin
            r_state <= S_DONE;
            r_fdone <= 1'b1;
            r_timer <= r_timer + 32'd1;
          end
        end
        S_DONE: begin
          r_state <= start_in ? S_DISPATCH : S_IDLE;
          r_busy  <= start_in;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pix_x_out      = r_x;
  assign pix_y_out      = r_y;
  assign timer_out      = r_timer;
  assign fb_we_out      = r_we;
  assign fb_addr_out    = r_addr;
  assign fb_data_out    = r_data;
  assign frame_done_out = r_fdone;
  assign busy_out       = r_busy;

endmodule

// File: tb/tb_raymarch_scheduler.sv
// tb_raymarch_scheduler: table vectors for dispatch/arbitration, reset
// sequences, and randomized frames against a behavioural core+frame model.
module tb_raymarch_scheduler;
  localparam int W  = 8;
  localparam int H  = 4;
  localparam int N  = 4;
  localparam int XW = 3;
  localparam int YW = 2;
  localparam int AW = 5;
  localparam int NPIX = W * H;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [N-1:0]    ready;
  logic [N-1:0]    cstart;
  logic [XW-1:0]   pix_x;
  logic [YW-1:0]   pix_y;
  logic [31:0]     timer;
  logic [N-1:0]    done;
  logic [N*XW-1:0] cx_in;
  logic [N*YW-1:0] cy_in;
  logic [N*24-1:0] rgb_in;
  logic [N-1:0]    ack;
  logic            fb_we;
  logic [AW-1:0]   fb_addr;
  logic [23:0]     fb_data;
  logic            fdone;
  logic            busy;

  raymarch_scheduler #(
    .WIDTH(W),
    .HEIGHT(H),
    .NUM_CORES(N)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .start_in(start),
    .core_ready_in(ready),
    .core_start_out(cstart),
    .pix_x_out(pix_x),
    .pix_y_out(pix_y),
    .timer_out(timer),
    .core_done_in(done),
    .core_x_in(cx_in),
    .core_y_in(cy_in),
    .core_rgb_in(rgb_in),
    .core_ack_out(ack),
    .fb_we_out(fb_we),
    .fb_addr_out(fb_addr),
    .fb_data_out(fb_data),
    .frame_done_out(fdone),
    .busy_out(busy)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  rdy;
    logic [3:0]  dn;
    logic [3:0]  st;
    logic [3:0]  ak;
    logic        we;
    logic [4:0]  addr;
    logic [23:0] data;
    int          pix;
  } vec_t;

  vec_t tv[7];

  // behavioural core + frame model state
  int         cnt[N];
  bit         hold[N];
  int         coord[N];
  int         wcnt[NPIX];
  int         mode;
  int         ndisp;
  int         ngrant;
  int         frames;
  int         rrp;
  logic [3:0] prev_ack;
  int         exp_addr;
  int         idle_cnt;
  bit         fin;

  function automatic logic [23:0] pix_rgb(input int c);
    logic [7:0] x;
    logic [7:0] y;
    x = 8'(c % W);
    y = 8'(c / W);
    return {x, y, x ^ y};
  endfunction

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < N; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  function automatic int rr_pick(input logic [3:0] v, input int p);
    for (int k = 1; k <= N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic apply_cores();
    for (int i = 0; i < N; i++) begin
      ready[i]           = (cnt[i] == 0) && !hold[i];
      done[i]            = hold[i];
      cx_in[i*XW +: XW]  = XW'(coord[i] % W);
      cy_in[i*YW +: YW]  = YW'(coord[i] / W);
      rgb_in[i*24 +: 24] = pix_rgb(coord[i]);
    end
  endtask

  task automatic new_frame();
    ndisp  = 0;
    ngrant = 0;
    for (int a = 0; a < NPIX; a++) wcnt[a] = 0;
  endtask

  initial begin
    tv[0] = '{4'b1111, 4'b0000, 4'b0001, 4'b0000, 1'b0, 5'd0,  24'h0,       0};
    tv[1] = '{4'b1110, 4'b0001, 4'b0010, 4'b0001, 1'b0, 5'd0,  24'h0,       1};
    tv[2] = '{4'b1100, 4'b0101, 4'b0100, 4'b0100, 1'b1, 5'd8,  24'hA00000,  2};
    tv[3] = '{4'b1000, 4'b0001, 4'b1000, 4'b0001, 1'b1, 5'd10, 24'hA00002,  3};
    tv[4] = '{4'b0000, 4'b1010, 4'b0000, 4'b0010, 1'b1, 5'd8,  24'hA00000, -1};
    tv[5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 5'd9,  24'hA00001, -1};
    tv[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 5'd0,  24'h0,      -1};

    rst   = 1'b1;
    start = 1'b0;
    ready = '0;
    done  = '0;
    for (int i = 0; i < N; i++) begin
      cx_in[i*XW +: XW]  = XW'(i);
      cy_in[i*YW +: YW]  = YW'(1);
      rgb_in[i*24 +: 24] = 24'hA00000 | 24'(i);
    end
    repeat (2) @(posedge clk);
    #1;
    ready = 4'b1111;
    done  = 4'b1111;
    @(negedge clk);
    chk("start_in_reset", cstart, 4'b0000);
    chk("ack_in_reset", ack, 4'b0000);

    // reset state, IDLE ignores ready and done
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fb_we", fb_we, 1'b0);
    chk("rst_fb_addr", fb_addr, 5'd0);
    chk("rst_fb_data", fb_data, 24'd0);
    chk("rst_frame_done", fdone, 1'b0);
    chk("rst_timer", timer, 32'd0);
    chk("rst_pix_x", pix_x, 3'd0);
    chk("rst_pix_y", pix_y, 2'd0);
    chk("idle_start", cstart, 4'b0000);
    chk("idle_ack", ack, 4'b0000);

    tick();
    start = 1'b1;
    ready = '0;
    done  = '0;

    // table: dispatch priority, round-robin grant, 1-cycle write latency
    for (int k = 0; k < 7; k++) begin
      tick();
      ready = tv[k].rdy;
      done  = tv[k].dn;
      @(negedge clk);
      chk($sformatf("tv%0d_start", k), cstart, tv[k].st);
      chk($sformatf("tv%0d_ack", k), ack, tv[k].ak);
      chk($sformatf("tv%0d_we", k), fb_we, tv[k].we);
      chk($sformatf("tv%0d_busy", k), busy, 1'b1);
      if (tv[k].we) begin
        chk($sformatf("tv%0d_addr", k), fb_addr, tv[k].addr);
        chk($sformatf("tv%0d_data", k), fb_data, tv[k].data);
      end
      if (tv[k].pix >= 0)
        chk($sformatf("tv%0d_pix", k), pix_x + W * pix_y, tv[k].pix);
    end

    // walk to pixel (5,1), then reset mid-frame
    done = '0;
    for (int k = 0; k < 9; k++) begin
      tick();
      ready = 4'b0001;
    end
    tick();
    ready = '0;
    @(negedge clk);
    chk("mid_pix_x", pix_x, 3'd5);
    chk("mid_pix_y", pix_y, 2'd1);
    tick();
    rst   = 1'b1;
    ready = 4'b1111;
    done  = 4'b1111;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_pix_x", pix_x, 3'd0);
    chk("mid_rst_pix_y", pix_y, 2'd0);
    chk("mid_rst_fb_we", fb_we, 1'b0);
    chk("mid_rst_timer", timer, 32'd0);
    chk("mid_rst_start", cstart, 4'b0000);
    chk("mid_rst_ack", ack, 4'b0000);
    tick();
    @(negedge clk);
    chk("post_rst_fb_we", fb_we, 1'b0);
    chk("post_rst_start", cstart, 4'b0000);

    // randomized frames: frame 1 with start held, frame 2 drops it
    for (int i = 0; i < N; i++) begin
      cnt[i]   = 0;
      hold[i]  = 1'b0;
      coord[i] = 0;
    end
    mode     = 0;
    frames   = 0;
    rrp      = N - 1;
    prev_ack = '0;
    exp_addr = 0;
    idle_cnt = 0;
    fin      = 1'b0;
    new_frame();
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      logic [3:0] es;
      logic [3:0] ea;
      int         d;
      int         g;
      int         ng0;
      tick();
      apply_cores();
      start = (frames == 0) || (mode == 3 && frames == 1);
      @(negedge clk);
      d  = (mode == 1) ? lowest(ready) : -1;
      g  = (mode == 1 || mode == 2) ? rr_pick(done, rrp) : -1;
      es = (d >= 0) ? 4'(1 << d) : 4'b0000;
      ea = (g >= 0) ? 4'(1 << g) : 4'b0000;
      chk("rnd_start", cstart, es);
      chk("rnd_ack", ack, ea);
      chk("rnd_busy", busy, mode != 0);
      chk("rnd_frame_done", fdone, mode == 3);
      chk("rnd_timer", timer, frames);
      chk("rnd_fb_we", fb_we, prev_ack != 0);
      if (fb_we === 1'b1) begin
        chk("rnd_fb_addr", fb_addr, exp_addr);
        chk("rnd_fb_data", fb_data, pix_rgb(int'(fb_addr)));
        wcnt[fb_addr]++;
      end
      if (d >= 0)
        chk("rnd_pix", pix_x + W * pix_y, ndisp);

      // core progress, then ack and dispatch effects
      for (int i = 0; i < N; i++) begin
        if (cnt[i] > 0) begin
          cnt[i]--;
          if (cnt[i] == 0) hold[i] = 1'b1;
        end
      end
      ng0      = ngrant;
      prev_ack = ea;
      if (g >= 0) begin
        exp_addr = coord[g];
        hold[g]  = 1'b0;
        rrp      = g;
        ngrant++;
      end
      if (d >= 0) begin
        cnt[d]   = $urandom_range(1, 20);
        coord[d] = ndisp;
        ndisp++;
      end

      case (mode)
        0: begin
          if (frames == 2) begin
            idle_cnt++;
            if (idle_cnt >= 6) fin = 1'b1;
          end else if (start) begin
            mode = 1;
            new_frame();
          end
        end
        1: if (ndisp == NPIX) mode = 2;
        2: begin
          if (ng0 == ndisp && g < 0) begin
            mode = 3;
            frames++;
            for (int a = 0; a < NPIX; a++)
              chk($sformatf("frame%0d_wcount_%0d", frames, a), wcnt[a], 1);
          end
        end
        default: begin
          if (start) begin
            mode = 1;
            new_frame();
          end else begin
            mode = 0;
          end
        end
      endcase
    end
    if (!fin) begin
      nvec++;
      nmis++;
      $display("FAIL rnd_timeout: got mode %0d frames %0d want 2 frames",
               mode, frames);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
